// File: rtl/display_pkg.sv
// Shared types and constants for the display scheduler and its helpers.
// The scheduler time-shares one 7-segment converter between three sources.
package display_pkg;

  // Default width of every source value and of the presented value.
  localparam int VALUE_W = 11;

  // Number of value sources competing for the display.
  localparam int NUM_SRC = 3;

  // Scheduler states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_STALE,
    WAIT_FRESH,
    SHOW
  } sched_state_t;

  // Source indices.
  localparam logic [1:0] SRC_SCORE   = 2'd0;
  localparam logic [1:0] SRC_TIME    = 2'd1;
  localparam logic [1:0] SRC_HISCORE = 2'd2;

  // Round-robin successor of a source index, wrapping hiscore back to score.
  function automatic logic [1:0] src_next(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      SRC_SCORE: nxt = SRC_TIME;
      SRC_TIME:  nxt = SRC_HISCORE;
      default:   nxt = SRC_SCORE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first enabled source at or after ptr_i,
// searching upward and wrapping past the last source.
module rr_pick
  import display_pkg::*;
(
  input  logic [1:0]         ptr_i,
  input  logic [NUM_SRC-1:0] src_en_i,
  output logic [1:0]         sel_o,
  output logic               any_en_o
);

  // Scan every source once starting at the pointer; keep the first hit.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    sel_o = SRC_SCORE;
    found = 1'b0;
    idx   = (ptr_i >= 2'(NUM_SRC)) ? SRC_SCORE : ptr_i;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && src_en_i[idx]) begin
        sel_o = idx;
        found = 1'b1;
      end
      idx = src_next(idx);
    end
  end

  assign any_en_o = |src_en_i;

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the four-digit 7-segment converter between the score, time
// remaining and high score counters. Each selected value is held on the
// converter input until a conversion that started after the change has
// finished, then shown for a fixed dwell before rotating to the next source.
module display_scheduler #(
  parameter int VALUE_W   = display_pkg::VALUE_W,
  parameter int DWELL     = 1000,
  parameter int TIMEOUT   = 256,
  parameter int MAX_VALUE = 1999
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [display_pkg::NUM_SRC*VALUE_W-1:0] src_value,
  input  logic [display_pkg::NUM_SRC-1:0]         src_en,
  input  logic                                   urgent,
  input  logic                                   conv_done,
  output logic [VALUE_W-1:0]                     value_out,
  output logic [1:0]                             src_sel,
  output logic                                   disp_valid,
  output logic                                   blank,
  output logic                                   timeout_err
);

  import display_pkg::*;

  // Dwell and wait counters share one width, large enough for either limit.
  localparam int CNT_MAX = (DWELL > TIMEOUT) ? DWELL : TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [VALUE_W-1:0] MAX_V     = VALUE_W'(MAX_VALUE);
  localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SHOW_LAST = CNT_W'(DWELL - 1);

  // FSM state and source bookkeeping.
  sched_state_t state_q, state_d;
  logic [1:0]   load_sel_q, load_sel_d;   // source the next LOAD samples
  logic [1:0]   ptr_q, ptr_d;             // next candidate for rotation
  logic         urgent_q;                 // urgent delayed, for edge detection

  // Registered outputs and counters.
  logic [VALUE_W-1:0] value_q, value_d;
  logic [1:0]         sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               blank_q, blank_d;
  logic               terr_q, terr_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;

  // Decoded conditions.
  logic               urgent_rise, urgent_fall;
  logic               in_wait, in_busy;
  logic               wait_expired, dwell_expired;
  logic               src_dropped, timeout_fire;
  logic [1:0]         ptr_eff, alt_start;
  logic [1:0]         rot_sel, alt_sel;
  logic               rot_any, alt_any;
  logic [VALUE_W-1:0] load_raw, load_val;

  assign urgent_rise = urgent & ~urgent_q;
  assign urgent_fall = ~urgent & urgent_q;

  // Rotation restarts at the time source the moment urgent is released.
  assign ptr_eff   = urgent_fall ? SRC_TIME : ptr_q;
  assign alt_start = src_next(sel_q);

  // Regular rotation candidate.
  rr_pick u_rot_pick (
    .ptr_i    (ptr_eff),
    .src_en_i (src_en),
    .sel_o    (rot_sel),
    .any_en_o (rot_any)
  );

  // Replacement candidate when the presented source is switched off.
  rr_pick u_alt_pick (
    .ptr_i    (alt_start),
    .src_en_i (src_en),
    .sel_o    (alt_sel),
    .any_en_o (alt_any)
  );

  assign in_wait       = (state_q == WAIT_STALE) || (state_q == WAIT_FRESH);
  assign in_busy       = in_wait || (state_q == SHOW);
  assign wait_expired  = (wait_q == WAIT_LAST);
  assign dwell_expired = (dwell_q == SHOW_LAST);

  // A forced score display during urgent ignores the score enable.
  assign src_dropped  = in_busy && !urgent && !src_en[sel_q];
  assign timeout_fire = in_wait && wait_expired && !conv_done &&
                        !urgent_rise && !src_dropped;

  // Value presented to the converter, clamped to the displayable range.
  assign load_raw = src_value[int'(load_sel_q)*VALUE_W +: VALUE_W];
  assign load_val = (load_raw > MAX_V) ? MAX_V : load_raw;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    if (rst) begin
      state_q    <= IDLE;
      load_sel_q <= SRC_SCORE;
      ptr_q      <= SRC_SCORE;
      urgent_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_sel_q <= load_sel_d;
      ptr_q      <= ptr_d;
      urgent_q   <= urgent;
    end
  end

  // Next-state logic: urgent rise beats source loss, which beats timeout,
  // which beats the normal done/dwell progression.
  always_comb begin
    state_d    = state_q;
    load_sel_d = load_sel_q;
    ptr_d      = ptr_eff;
    if (state_q == IDLE) begin
      if (rot_any) begin
        state_d = LOAD;
        if (urgent) begin
          load_sel_d = SRC_SCORE;
        end else begin
          load_sel_d = rot_sel;
          ptr_d      = src_next(rot_sel);
        end
      end
    end else if (urgent_rise) begin
      state_d    = LOAD;
      load_sel_d = SRC_SCORE;
    end else if (src_dropped) begin
      if (alt_any) begin
        state_d    = LOAD;
        load_sel_d = alt_sel;
        ptr_d      = src_next(alt_sel);
      end else begin
        state_d = IDLE;
      end
    end else if (timeout_fire) begin
      state_d    = LOAD;
      load_sel_d = sel_q;
    end else begin
      case (state_q)
        LOAD:       state_d = WAIT_STALE;
        WAIT_STALE: if (conv_done) state_d = WAIT_FRESH;
        WAIT_FRESH: if (conv_done) state_d = SHOW;
        SHOW: begin
          if (dwell_expired) begin
            state_d = LOAD;
            if (urgent) begin
              load_sel_d = SRC_SCORE;
            end else begin
              load_sel_d = rot_sel;
              ptr_d      = src_next(rot_sel);
            end
          end
        end
        default:    state_d = IDLE;
      endcase
    end
  end

  // Output and counter next values, derived from the current/next state.
  always_comb begin
    value_d = value_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    blank_d = (state_d == IDLE);
    terr_d  = timeout_fire;
    wait_d  = '0;
    dwell_d = '0;
    if (state_q == LOAD) begin
      value_d = load_val;
      sel_d   = load_sel_q;
    end
    if ((state_d == LOAD) || (state_d == IDLE)) begin
      valid_d = 1'b0;
    end else if ((state_q == WAIT_FRESH) && (state_d == SHOW)) begin
      valid_d = 1'b1;
    end
    if (in_wait && ((state_d == WAIT_STALE) || (state_d == WAIT_FRESH))) begin
      wait_d = wait_q + CNT_W'(1);
    end
    if ((state_q == SHOW) && (state_d == SHOW)) begin
      dwell_d = dwell_q + CNT_W'(1);
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      sel_q   <= SRC_SCORE;
      valid_q <= 1'b0;
      blank_q <= 1'b1;
      terr_q  <= 1'b0;
      wait_q  <= '0;
      dwell_q <= '0;
    end else begin
      value_q <= value_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      terr_q  <= terr_d;
      wait_q  <= wait_d;
      dwell_q <= dwell_d;
    end
  end

  assign value_out   = value_q;
  assign src_sel     = sel_q;
  assign disp_valid  = valid_q;
  assign blank       = blank_q;
  assign timeout_err = terr_q;

endmodule
